// File: rtl/pe_pkg.sv
// Shared PE definitions: FSM state encoding and the requantisation function
// reused by the MAC, pooling and bias blocks.
`default_nettype none

package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } pe_state_t;

  localparam int REQ_W = 64;

  // The caller sign-extends the accumulator to REQ_W bits. The extra headroom
  // means the rounding add cannot overflow for any ACC_W up to REQ_W-2.
  function automatic logic signed [REQ_W-1:0] requantise(
      input logic signed [REQ_W-1:0] acc,
      input int                      shift,
      input logic                    relu,
      input int                      data_w
  );
    logic signed [REQ_W-1:0] r;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    r = acc;
    if (shift != 0) begin
      r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    if (relu && (r < 64'sd0)) begin
      r = '0;
    end
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_mac_acc_if.sv
// Operand and output valid/ready streams of a MAC processing element.
`default_nettype none

interface pe_mac_acc_if #(
    parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] ifm;
  logic signed [DATA_W-1:0] weight;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] ofm;

  modport master (
      output in_valid, ifm, weight, out_ready,
      input  in_ready, out_valid, ofm
  );

  modport slave (
      input  in_valid, ifm, weight, out_ready,
      output in_ready, out_valid, ofm
  );
endinterface

`default_nettype wire

// File: rtl/pe_requant.sv
// Combinational requantisation: round, arithmetic shift, optional ReLU, saturate.
`default_nettype none

module pe_requant
  import pe_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 5
) (
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [SHIFT_W-1:0] i_shift,
    input  logic                      i_relu,
    output logic signed [DATA_W-1:0]  o_ofm
);

  logic signed [REQ_W-1:0] w_acc_ext;

  assign w_acc_ext = REQ_W'(i_acc);
  assign o_ofm     = DATA_W'(requantise(w_acc_ext, int'(i_shift), i_relu, DATA_W));

endmodule

`default_nettype wire

// File: rtl/pe_mac_acc.sv
// MAC processing element: accumulates cfg_len signed products, then presents
// one requantised output pixel on a valid/ready stream.
`default_nettype none

module pe_mac_acc
  import pe_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 12,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic [SHIFT_W-1:0] i_cfg_shift,
    input  logic               i_cfg_relu,
    pe_mac_acc_if.slave        s_bus,
    output logic [ACC_W-1:0]   o_acc_out,
    output logic               o_busy
);

  pe_state_t                 r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [LEN_W-1:0]   r_count;
  logic        [LEN_W-1:0]   r_len;
  logic        [SHIFT_W-1:0] r_shift;
  logic                      r_relu;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic                       w_last;

  assign w_prod     = (2*DATA_W)'(s_bus.ifm) * (2*DATA_W)'(s_bus.weight);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_last     = (r_count == (r_len - LEN_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len   <= i_cfg_len;
            r_shift <= i_cfg_shift;
            r_relu  <= i_cfg_relu;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            // A zero-length job has nothing to accumulate: emit 0 straight away.
            if (i_cfg_len == '0) begin
              r_state     <= ST_OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ST_ACC;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (s_bus.in_valid) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + LEN_W'(1);
            if (w_last) begin
              r_state     <= ST_OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (s_bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  pe_requant #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SHIFT_W(SHIFT_W)
  ) u_requant (
      .i_acc  (r_acc),
      .i_shift(r_shift),
      .i_relu (r_relu),
      .o_ofm  (s_bus.ofm)
  );

  assign s_bus.in_ready  = r_in_ready;
  assign s_bus.out_valid = r_out_valid;
  assign o_acc_out       = r_acc;
  assign o_busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pe_mac_acc.sv
// Directed self-checking bench for pe_mac_acc with hand-computed expectations.
`default_nettype none

module tb_pe_mac_acc;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [23:0] acc_out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  pe_mac_acc_if #(.DATA_W(8)) bus ();

  pe_mac_acc #(
      .DATA_W (8),
      .ACC_W  (24),
      .LEN_W  (12),
      .SHIFT_W(5)
  ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_start    (start),
      .i_cfg_len  (cfg_len),
      .i_cfg_shift(cfg_shift),
      .i_cfg_relu (cfg_relu),
      .s_bus      (bus),
      .o_acc_out  (acc_out),
      .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, int'(bus.in_ready), 0);
    chk({tag, ".out_valid"}, int'(bus.out_valid), 0);
    chk({tag, ".busy"}, int'(busy), 0);
  endtask

  task automatic start_op(input int len, input int shift, input logic relu);
    cfg_len   = 12'(len);
    cfg_shift = 5'(shift);
    cfg_relu  = relu;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_len   = 12'hABC;
    cfg_shift = 5'd7;
    cfg_relu  = 1'b1;
  endtask

  task automatic pair(input int a, input int b);
    bus.in_valid = 1'b1;
    bus.ifm      = 8'(a);
    bus.weight   = 8'(b);
    tick();
    bus.in_valid = 1'b0;
    bus.ifm      = 8'h55;
    bus.weight   = 8'h7F;
  endtask

  task automatic out_hs();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int e_ofm, input int e_acc);
    chk({tag, ".out_valid"}, int'(bus.out_valid), 1);
    chk({tag, ".ofm"}, int'(bus.ofm), e_ofm);
    chk({tag, ".acc"}, int'($signed(acc_out)), e_acc);
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    cfg_len       = '0;
    cfg_shift     = '0;
    cfg_relu      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ifm       = '0;
    bus.weight    = '0;
    bus.out_ready = 1'b0;

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      start        = i[0];
      bus.in_valid = ~i[0];
      bus.ifm      = 8'(i + 3);
      bus.weight   = 8'(i + 5);
      cfg_len      = 12'(i + 1);
      tick();
      chk_idle("rst");
      chk("rst.ofm", int'(bus.ofm), 0);
      chk("rst.acc", int'($signed(acc_out)), 0);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    tick();
    chk_idle("post_rst");

    // len=3, shift=0: 6 - 20 + 7 = -7
    start_op(3, 0, 1'b0);
    chk("a.in_ready", int'(bus.in_ready), 1);
    chk("a.busy", int'(busy), 1);
    pair(2, 3);
    pair(-4, 5);
    chk("a.early_valid", int'(bus.out_valid), 0);
    pair(7, 1);
    chk_out("a", -7, -7);
    chk("a.in_ready_out", int'(bus.in_ready), 0);
    out_hs();
    chk_idle("a.done");

    // len=2, shift=2: 100 + 6 = 106, (106+2)>>2 = 27
    start_op(2, 2, 1'b0);
    pair(10, 10);
    pair(3, 2);
    chk_out("b", 27, 106);
    out_hs();

    // relu: -100 + 1 = -99 -> rounds to -25 -> clamped to 0
    start_op(2, 2, 1'b1);
    pair(-10, 10);
    pair(1, 1);
    chk_out("c", 0, -99);
    out_hs();

    // Positive saturation: 4 * 16129 = 64516
    start_op(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) pair(127, 127);
    chk_out("satp", 127, 64516);
    out_hs();

    // Negative saturation: 4 * -16256 = -65024
    start_op(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) pair(-128, 127);
    chk_out("satn", -128, -65024);
    out_hs();

    // Gaps in in_valid: 30 - 6 + 1 = 25
    start_op(3, 0, 1'b0);
    pair(5, 6);
    tick();
    chk("gap1.acc", int'($signed(acc_out)), 30);
    pair(-2, 3);
    tick();
    tick();
    chk("gap2.acc", int'($signed(acc_out)), 24);
    chk("gap2.in_ready", int'(bus.in_ready), 1);
    pair(1, 1);
    // Hold with out_ready low; start during OUT must be ignored
    cfg_len = 12'd0;
    start   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_out("hold", 25, 25);
      tick();
    end
    start = 1'b0;
    chk_out("hold_end", 25, 25);
    out_hs();
    chk_idle("hold.done");
    tick();
    chk_idle("hold.idle2");

    // len=0 -> output 0 one cycle after start
    start_op(0, 0, 1'b0);
    chk_out("len0", 0, 0);
    chk("len0.in_ready", int'(bus.in_ready), 0);
    out_hs();
    chk_idle("len0.done");

    // Asynchronous reset mid-accumulation
    start_op(3, 1, 1'b1);
    pair(5, 5);
    chk("rmid.acc_pre", int'($signed(acc_out)), 25);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("rmid.async");
    chk("rmid.acc", int'($signed(acc_out)), 0);
    tick();
    chk_idle("rmid.next");
    chk("rmid.ofm", int'(bus.ofm), 0);
    reset_n = 1'b1;
    tick();

    // len=1 after reset: 3 * -3 = -9
    start_op(1, 0, 1'b0);
    pair(3, -3);
    chk_out("post", -9, -9);
    out_hs();
    chk_idle("post.done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
